// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin arbiter sequencing one bus transaction at a time
module bus_master_arb #(
  parameter int NUM_REQ    = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [16*NUM_REQ-1:0] req_addr,
  input  logic [16*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [15:0]          rd_data,
  output logic                 bus_cmd_valid_mst,
  output logic                 bus_op_mst,
  output logic [15:0]          bus_addr_mst,
  output logic [15:0]          bus_wr_data_mst,
  input  logic [15:0]          bus_rd_data_mst
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = 3;
  localparam logic [PW:0] NQ = (PW+1)'(NUM_REQ);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
  state_t r_state, w_state;
  logic [NUM_REQ-1:0] r_gnt, w_gnt, r_done, w_done, w_oh;
  logic [15:0] r_rd_data, w_rd_data, r_addr, w_addr, r_wdata, w_wdata, w_f_addr, w_f_wdata;
  logic r_cmd_valid, w_cmd_valid, r_op, w_op, w_f_op;
  logic [PW-1:0] r_ptr, w_ptr, w_nptr;
  logic [PW:0] w_s;
  logic [CW-1:0] r_cnt, w_cnt;
  // first requesting index found searching ptr, ptr+1, ... (lowest offset wins)
  always_comb begin
    w_oh = '0;
    w_s = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      w_s = {1'b0, r_ptr} + (PW+1)'(i);
      w_s = (w_s >= NQ) ? w_s - NQ : w_s;
      if (req[w_s[PW-1:0]]) w_oh = NUM_REQ'(1) << w_s[PW-1:0];
    end
  end
  // command fields of the selected requester and the pointer past the granted one
  always_comb begin
    w_f_op = 1'b0;
    w_f_addr = '0;
    w_f_wdata = '0;
    w_nptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_oh[i]) begin
        w_f_op = req_op[i];
        w_f_addr = req_addr[16*i +: 16];
        w_f_wdata = req_wr_data[16*i +: 16];
      end
      if (r_gnt[i]) w_nptr = (i == NUM_REQ-1) ? '0 : PW'(i+1);
    end
  end
  // next state and next register values; done and cmd strobe default low
  always_comb begin
    w_state = r_state;
    w_gnt = r_gnt;
    w_done = '0;
    w_rd_data = r_rd_data;
    w_cmd_valid = 1'b0;
    w_op = r_op;
    w_addr = r_addr;
    w_wdata = r_wdata;
    w_ptr = r_ptr;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (|req) begin
        w_state = CMD;
        w_gnt = w_oh;
        w_cmd_valid = 1'b1;
        w_op = w_f_op;
        w_addr = w_f_addr;
        w_wdata = w_f_wdata;
      end
      CMD: begin
        w_state = r_op ? DONE : WAIT;
        w_done = r_op ? r_gnt : '0;
        w_cnt = r_op ? r_cnt : CW'(RD_LATENCY-1);
      end
      WAIT: if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
      else begin
        w_state = DONE;
        w_done = r_gnt;
        w_rd_data = bus_rd_data_mst;
      end
      DONE: begin
        w_state = IDLE;
        w_gnt = '0;
        w_ptr = w_nptr;
      end
      default: w_state = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_done <= '0;
      r_rd_data <= '0;
      r_cmd_valid <= 1'b0;
      r_op <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_gnt <= w_gnt;
      r_done <= w_done;
      r_rd_data <= w_rd_data;
      r_cmd_valid <= w_cmd_valid;
      r_op <= w_op;
      r_addr <= w_addr;
      r_wdata <= w_wdata;
      r_ptr <= w_ptr;
      r_cnt <= w_cnt;
    end
  end
  assign gnt = r_gnt;
  assign done = r_done;
  assign rd_data = r_rd_data;
  assign bus_cmd_valid_mst = r_cmd_valid;
  assign bus_op_mst = r_op;
  assign bus_addr_mst = r_addr;
  assign bus_wr_data_mst = r_wdata;
endmodule
